enc_dec_apb_rgf: RTL and testbench

Parametrised APB register file for the encoder/decoder top. It replaces the fixed four-register block with configurable read/write and read-only register counts, full APB3 signalling (pready with programmable wait states, pslverr), a self-clearing start bit, and a write-1-to-clear interrupt register with mask and `irq` output. It sits between the APB master and the encoder/decoder core.

---
 rtl/enc_dec_apb_rgf_pkg.sv | 25 ++
 rtl/enc_dec_int_ctrl.sv | 42 ++++
 rtl/enc_dec_apb_rgf.sv | 153 +++++++++++++++
 tb/tb_enc_dec_apb_rgf.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/enc_dec_apb_rgf_pkg.sv
// rtl/enc_dec_apb_rgf_pkg.sv - shared types, constants and map helpers for the APB register file
package enc_dec_rgf_pkg;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_ACCESS = 1'b1
   } rgf_state_e;

   localparam int ADDR_LSB       = 2;
   localparam int CTRL_START_BIT = 0;

   // RW block, RO block, then INT_STATUS and INT_MASK.
   function automatic int idx_w(input int num_rw, input int num_ro);
      return $clog2(num_rw + num_ro + 2);
   endfunction

   function automatic int int_status_idx(input int num_rw, input int num_ro);
      return num_rw + num_ro;
   endfunction

   function automatic int int_mask_idx(input int num_rw, input int num_ro);
      return num_rw + num_ro + 1;
   endfunction

endpackage

// File: rtl/enc_dec_int_ctrl.sv
// rtl/enc_dec_int_ctrl.sv - interrupt status (W1C), mask and registered irq
module enc_dec_int_ctrl #(
   parameter int NUM_INT = 4
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [NUM_INT-1:0] int_set_i,
   input  logic               status_wr_i,
   input  logic               mask_wr_i,
   input  logic [NUM_INT-1:0] wdata_i,
   output logic [NUM_INT-1:0] int_status_o,
   output logic [NUM_INT-1:0] int_mask_o,
   output logic               irq_o
);

   logic [NUM_INT-1:0] status_q, status_d;
   logic [NUM_INT-1:0] mask_q, mask_d;
   logic               irq_q;

   // A set pulse in the same cycle as a clear keeps the bit set.
   always_comb begin
      status_d = (status_q & ~(status_wr_i ? wdata_i : '0)) | int_set_i;
      mask_d   = mask_wr_i ? wdata_i : mask_q;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         status_q <= '0;
         mask_q   <= '0;
         irq_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         mask_q   <= mask_d;
         irq_q    <= |(status_q & mask_q);
      end
   end

   assign int_status_o = status_q;
   assign int_mask_o   = mask_q;
   assign irq_o        = irq_q;

endmodule

// File: rtl/enc_dec_apb_rgf.sv
// rtl/enc_dec_apb_rgf.sv - parametrised APB3 register file for the encoder/decoder core
module enc_dec_apb_rgf
   import enc_dec_rgf_pkg::*;
#(
   parameter int AMBA_ADDR_WIDTH = 32,
   parameter int AMBA_WORD       = 32,
   parameter int NUM_RW_REGS     = 4,
   parameter int NUM_RO_REGS     = 2,
   parameter int NUM_INT         = 4,
   parameter int WAIT_STATES     = 0
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic [AMBA_ADDR_WIDTH-1:0]         paddr,
   input  logic [AMBA_WORD-1:0]               pwdata,
   input  logic                               psel,
   input  logic                               penable,
   input  logic                               pwrite,
   output logic [AMBA_WORD-1:0]               prdata,
   output logic                               pready,
   output logic                               pslverr,
   output logic                               regs_wr_en,
   output logic [NUM_RW_REGS*AMBA_WORD-1:0]   rw_regs,
   output logic                               ctrl_start,
   input  logic [NUM_RO_REGS*AMBA_WORD-1:0]   ro_regs_in,
   input  logic [NUM_INT-1:0]                 int_set,
   output logic                               irq
);

   localparam int IDX_W = idx_w(NUM_RW_REGS, NUM_RO_REGS);
   localparam int NUM_REGS = NUM_RW_REGS + NUM_RO_REGS + 2;
   localparam logic [IDX_W-1:0] RO_LO    = IDX_W'(NUM_RW_REGS);
   localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(int_status_idx(NUM_RW_REGS, NUM_RO_REGS));
   localparam logic [IDX_W-1:0] MASK_IDX = IDX_W'(int_mask_idx(NUM_RW_REGS, NUM_RO_REGS));
   localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_END = AMBA_ADDR_WIDTH'(4 * NUM_REGS);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [AMBA_WORD-1:0] START_MASK = AMBA_WORD'(1) << CTRL_START_BIT;

   rgf_state_e           state_q, state_d;
   logic [3:0]           wcnt_q, wcnt_d;
   logic [IDX_W-1:0]     idx_q;
   logic                 wr_q, err_q;
   logic [AMBA_WORD-1:0] wdata_q;
   logic [AMBA_WORD-1:0] rw_q [NUM_RW_REGS];
   logic [AMBA_WORD-1:0] prdata_q;
   logic                 wr_en_q, start_q;
   logic [NUM_INT-1:0]   int_status, int_mask;

   logic [IDX_W-1:0]     in_idx, rd_idx;
   logic                 in_err, rd_err, setup, commit, load_rd;
   logic [AMBA_WORD-1:0] rd_val;

   assign in_idx  = paddr[ADDR_LSB +: IDX_W];
   assign in_err  = (paddr[ADDR_LSB-1:0] != '0) | (paddr >= ADDR_END)
                  | (pwrite & (in_idx >= RO_LO) & (in_idx < STAT_IDX));
   assign setup   = (state_q == S_IDLE) & psel & ~penable;
   assign pready  = (state_q == S_ACCESS) & (wcnt_q == WS);
   assign pslverr = pready & err_q;
   assign commit  = pready & psel & wr_q & ~err_q;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            if (setup) begin
               state_d = S_ACCESS;
               wcnt_d  = '0;
            end
         end
         S_ACCESS: begin
            if (!psel || pready) state_d = S_IDLE;
            else                 wcnt_d  = wcnt_q + 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // prdata is captured on the edge that enters the completing cycle.
   assign load_rd = (setup & ~pwrite & (WAIT_STATES == 0))
                  | ((state_q == S_ACCESS) & psel & ~pready & ~wr_q & ((wcnt_q + 4'd1) == WS));
   assign rd_idx  = (state_q == S_IDLE) ? in_idx : idx_q;
   assign rd_err  = (state_q == S_IDLE) ? in_err : err_q;

   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_RW_REGS; i++)
         if (rd_idx == IDX_W'(i)) rd_val = rw_q[i];
      for (int i = 0; i < NUM_RO_REGS; i++)
         if (rd_idx == IDX_W'(NUM_RW_REGS + i)) rd_val = ro_regs_in[i*AMBA_WORD +: AMBA_WORD];
      if (rd_idx == STAT_IDX) rd_val = AMBA_WORD'(int_status);
      if (rd_idx == MASK_IDX) rd_val = AMBA_WORD'(int_mask);
      if (rd_err)             rd_val = '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idx_q    <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         wdata_q  <= '0;
         prdata_q <= '0;
         wr_en_q  <= 1'b0;
         start_q  <= 1'b0;
         for (int i = 0; i < NUM_RW_REGS; i++) rw_q[i] <= '0;
      end else begin
         if (setup) begin
            idx_q   <= in_idx;
            wr_q    <= pwrite;
            err_q   <= in_err;
            wdata_q <= pwdata;
         end
         if (load_rd) prdata_q <= rd_val;
         wr_en_q <= commit;
         start_q <= commit & (idx_q == '0) & wdata_q[CTRL_START_BIT];
         // The start bit is a pulse, never stored.
         for (int i = 0; i < NUM_RW_REGS; i++)
            if (commit && idx_q == IDX_W'(i))
               rw_q[i] <= (i == 0) ? (wdata_q & ~START_MASK) : wdata_q;
      end
   end

   for (genvar g = 0; g < NUM_RW_REGS; g++) begin : g_rw_out
      assign rw_regs[g*AMBA_WORD +: AMBA_WORD] = rw_q[g];
   end

   enc_dec_int_ctrl #(.NUM_INT(NUM_INT)) u_int_ctrl (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .int_set_i    (int_set),
      .status_wr_i  (commit & (idx_q == STAT_IDX)),
      .mask_wr_i    (commit & (idx_q == MASK_IDX)),
      .wdata_i      (wdata_q[NUM_INT-1:0]),
      .int_status_o (int_status),
      .int_mask_o   (int_mask),
      .irq_o        (irq)
   );

   assign prdata     = prdata_q;
   assign regs_wr_en = wr_en_q;
   assign ctrl_start = start_q;

endmodule

// File: tb/tb_enc_dec_apb_rgf.sv
// tb/tb_enc_dec_apb_rgf.sv - directed vector bench for the APB register file
module tb_enc_dec_apb_rgf;

   logic         clk = 1'b0;
   logic         rstn;
   logic [31:0]  paddr, pwdata;
   logic         pwrite;
   logic         psel0, penable0, psel3, penable3;
   logic [31:0]  prdata0, prdata3;
   logic         pready0, pready3, pslverr0, pslverr3;
   logic         wr_en0, wr_en3, start0, start3, irq0, irq3;
   logic [127:0] rw0, rw3;
   logic [63:0]  ro_in = 64'hBEEF_0001_CAFE_0000;
   logic [3:0]   int_set;

   int checks = 0, errors = 0, wr_cnt = 0, start_cnt = 0;

   always #5 clk = ~clk;

   enc_dec_apb_rgf #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .pwdata(pwdata), .psel(psel0),
      .penable(penable0), .pwrite(pwrite), .prdata(prdata0), .pready(pready0),
      .pslverr(pslverr0), .regs_wr_en(wr_en0), .rw_regs(rw0), .ctrl_start(start0),
      .ro_regs_in(ro_in), .int_set(int_set), .irq(irq0)
   );

   enc_dec_apb_rgf #(.WAIT_STATES(3)) dut3 (
      .clk(clk), .rstn(rstn), .paddr(paddr), .pwdata(pwdata), .psel(psel3),
      .penable(penable3), .pwrite(pwrite), .prdata(prdata3), .pready(pready3),
      .pslverr(pslverr3), .regs_wr_en(wr_en3), .rw_regs(rw3), .ctrl_start(start3),
      .ro_regs_in(ro_in), .int_set(int_set), .irq(irq3)
   );

   always @(negedge clk) begin
      if (wr_en0) wr_cnt++;
      if (start0) start_cnt++;
   end

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      bit          exp_err;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic apb(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int cyc);
      @(posedge clk); #1;
      paddr = a; pwdata = d; pwrite = wr;
      if (d3) begin psel3 = 1'b1; penable3 = 1'b0; end
      else    begin psel0 = 1'b1; penable0 = 1'b0; end
      @(posedge clk); #1;
      if (d3) penable3 = 1'b1; else penable0 = 1'b1;
      cyc = 0; rd = '0; err = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (d3 ? pready3 : pready0) begin
            rd  = d3 ? prdata3 : prdata0;
            err = d3 ? pslverr3 : pslverr0;
            break;
         end
         if (cyc >= 32) begin
            checks++; errors++;
            $display("FAIL pready_timeout actual=%0d cycles expected=ready", cyc);
            break;
         end
      end
      @(posedge clk); #1;
      psel0 = 1'b0; penable0 = 1'b0; psel3 = 1'b0; penable3 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        err;
      int          cyc, w0;

      vecs[0]  = '{1'b1, 32'h04, 32'hA5A5_0000, 32'h0,         1'b0};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'hA5A5_0000, 1'b0};
      vecs[2]  = '{1'b1, 32'h00, 32'h0000_0003, 32'h0,         1'b0};
      vecs[3]  = '{1'b0, 32'h00, 32'h0,         32'h0000_0002, 1'b0};
      vecs[4]  = '{1'b0, 32'h10, 32'h0,         32'hCAFE_0000, 1'b0};
      vecs[5]  = '{1'b0, 32'h14, 32'h0,         32'hBEEF_0001, 1'b0};
      vecs[6]  = '{1'b1, 32'h10, 32'h1234_5678, 32'h0,         1'b1};
      vecs[7]  = '{1'b0, 32'h10, 32'h0,         32'hCAFE_0000, 1'b0};
      vecs[8]  = '{1'b1, 32'h22, 32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[9]  = '{1'b0, 32'h22, 32'h0,         32'h0,         1'b1};
      vecs[10] = '{1'b1, 32'h20, 32'hFFFF_FFFF, 32'h0,         1'b1};
      vecs[11] = '{1'b0, 32'h20, 32'h0,         32'h0,         1'b1};
      vecs[12] = '{1'b1, 32'h0C, 32'hDEAD_BEEF, 32'h0,         1'b0};
      vecs[13] = '{1'b0, 32'h0C, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[14] = '{1'b0, 32'h08, 32'h0,         32'h0,         1'b0};
      vecs[15] = '{1'b1, 32'h1C, 32'h0000_0004, 32'h0,         1'b0};
      vecs[16] = '{1'b0, 32'h1C, 32'h0,         32'h0000_0004, 1'b0};

      rstn = 1'b0; paddr = '0; pwdata = '0; pwrite = 1'b0; int_set = '0;
      psel0 = 1'b0; penable0 = 1'b0; psel3 = 1'b0; penable3 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_prdata", prdata0, 32'h0);
      check("rst_pready", {31'b0, pready0}, 32'h0);
      check("rst_pslverr", {31'b0, pslverr0}, 32'h0);
      check("rst_wr_en", {31'b0, wr_en0}, 32'h0);
      check("rst_start", {31'b0, start0}, 32'h0);
      check("rst_irq", {31'b0, irq0}, 32'h0);
      check("rst_rw", {31'b0, |rw0}, 32'h0);
      rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         w0 = wr_cnt;
         apb(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].data, rd, err, cyc);
         @(negedge clk); #1;
         check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
         if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("v%0d_cycles", i), cyc, 32'd1);
         check($sformatf("v%0d_wr_pulses", i), wr_cnt - w0,
               {31'b0, vecs[i].wr & ~vecs[i].exp_err});
      end
      check("ctrl_start_count", start_cnt, 32'd1);
      check("rw_regs_reg1", rw0[63:32], 32'hA5A5_0000);
      check("rw_regs_ctrl", rw0[31:0], 32'h0000_0002);

      apb(1'b1, 1'b0, 32'h00, 32'h0, rd, err, cyc);
      check("ws3_read_cycles", cyc, 32'd4);
      check("ws3_read_data", rd, 32'h0);
      apb(1'b1, 1'b1, 32'h08, 32'h0000_0055, rd, err, cyc);
      check("ws3_write_cycles", cyc, 32'd4);
      apb(1'b1, 1'b0, 32'h08, 32'h0, rd, err, cyc);
      check("ws3_readback", rd, 32'h0000_0055);

      @(posedge clk); #1 int_set = 4'b0100;
      @(posedge clk); #1 int_set = 4'b0000;
      @(negedge clk);
      check("irq_after_1", {31'b0, irq0}, 32'h0);
      @(negedge clk);
      check("irq_after_2", {31'b0, irq0}, 32'h1);
      apb(1'b0, 1'b0, 32'h18, 32'h0, rd, err, cyc);
      check("int_status_set", rd, 32'h4);

      // W1C commit edge coincides with a fresh set pulse.
      @(posedge clk); #1;
      paddr = 32'h18; pwdata = 32'h4; pwrite = 1'b1; psel0 = 1'b1; penable0 = 1'b0;
      @(posedge clk); #1;
      penable0 = 1'b1; int_set = 4'b0100;
      @(negedge clk);
      check("w1c_race_pready", {31'b0, pready0}, 32'h1);
      @(posedge clk); #1;
      psel0 = 1'b0; penable0 = 1'b0; int_set = 4'b0000;
      apb(1'b0, 1'b0, 32'h18, 32'h0, rd, err, cyc);
      check("set_wins_status", rd, 32'h4);
      check("set_wins_irq", {31'b0, irq0}, 32'h1);
      apb(1'b0, 1'b1, 32'h18, 32'h4, rd, err, cyc);
      apb(1'b0, 1'b0, 32'h18, 32'h0, rd, err, cyc);
      check("w1c_cleared", rd, 32'h0);
      @(negedge clk);
      check("irq_dropped", {31'b0, irq0}, 32'h0);

      apb(1'b0, 1'b0, 32'h0C, 32'h0, rd, err, cyc);
      check("pre_reset_read", rd, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      paddr = 32'h08; pwdata = 32'h1111_2222; pwrite = 1'b1; psel0 = 1'b1; penable0 = 1'b0;
      @(posedge clk); #1;
      penable0 = 1'b1;
      #2 rstn = 1'b0;
      @(negedge clk);
      check("mid_rst_pready", {31'b0, pready0}, 32'h0);
      check("mid_rst_prdata", prdata0, 32'h0);
      check("mid_rst_pslverr", {31'b0, pslverr0}, 32'h0);
      check("mid_rst_wr_en", {31'b0, wr_en0}, 32'h0);
      check("mid_rst_irq", {31'b0, irq0}, 32'h0);
      check("mid_rst_rw", {31'b0, |rw0}, 32'h0);
      @(posedge clk); #1;
      psel0 = 1'b0; penable0 = 1'b0;
      rstn = 1'b1;
      apb(1'b0, 1'b0, 32'h08, 32'h0, rd, err, cyc);
      check("post_rst_reg2", rd, 32'h0);
      check("post_rst_cycles", cyc, 32'd1);
      apb(1'b0, 1'b1, 32'h08, 32'h0000_0077, rd, err, cyc);
      apb(1'b0, 1'b0, 32'h08, 32'h0, rd, err, cyc);
      check("post_rst_readback", rd, 32'h0000_0077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
